// File: rtl/serializer_vrtl.sv
// Parallel-to-serial stage: one packed frame of N_SAMPLES words in, one word per beat out.
// Optional SERIALIZER_MSB_FIRST_EN emits the highest-index word first; default is word 0 first.
module serializer_vrtl #(
   parameter int BIT_WIDTH = 32,
   parameter int N_SAMPLES = 8
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [BIT_WIDTH*N_SAMPLES-1:0] recv_msg,
   input  logic                           recv_val,
   output logic                           recv_rdy,
   output logic [BIT_WIDTH-1:0]           send_msg,
   output logic                           send_val,
   input  logic                           send_rdy,
   output logic                           dbg_state
);

   localparam int CW = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1;
   localparam int FW = BIT_WIDTH * N_SAMPLES;
   localparam logic [CW-1:0] LAST = CW'(N_SAMPLES - 1);

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   state_t          state, state_nxt;
   logic [CW-1:0]   cnt, cnt_nxt;
   logic [FW-1:0]   buffer, buffer_nxt;
   logic            last_word;

   // Handshake: a transfer happens on a rising edge where val & rdy are both high.
   // send_val is never withdrawn once raised; recv_rdy combinationally follows send_rdy
   // on the last word so a new frame can be taken with no bubble.

   assign last_word = (cnt == LAST);
   assign dbg_state = (state == SEND);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= IDLE;
         cnt    <= '0;
         buffer <= '0;
      end else begin
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         buffer <= buffer_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      buffer_nxt = buffer;
      recv_rdy   = 1'b0;
      send_val   = 1'b0;
      case (state)
         IDLE: begin
            recv_rdy = 1'b1;
            if (recv_val) begin
               buffer_nxt = recv_msg;
               cnt_nxt    = '0;
               state_nxt  = SEND;
            end
         end
         SEND: begin
            send_val = 1'b1;
            recv_rdy = last_word & send_rdy;
            if (send_rdy) begin
               if (!last_word) begin
                  cnt_nxt = cnt + 1'b1;
               end else begin
                  cnt_nxt = '0;
                  if (recv_val) begin
                     buffer_nxt = recv_msg;
                  end else begin
                     state_nxt = IDLE;
                  end
               end
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   // Word select driven only by registered state, so recv_msg never reaches send_msg.
   always_comb begin
      send_msg = '0;
      if (state == SEND) begin
         for (int i = 0; i < N_SAMPLES; i++) begin
            if (cnt == CW'(i)) begin
`ifdef SERIALIZER_MSB_FIRST_EN
               send_msg = buffer[BIT_WIDTH*(N_SAMPLES-1-i) +: BIT_WIDTH];
`else
               send_msg = buffer[BIT_WIDTH*i +: BIT_WIDTH];
`endif
            end
         end
      end
   end

endmodule

// File: tb/tb_serializer_vrtl.sv
// Directed bench for serializer_vrtl: queue-based frame model, literal sequence checks,
// a 32x8 loopback into a packing model, and an N_SAMPLES==1 instance.
module tb_serializer_vrtl;

   localparam int BW = 4;
   localparam int NS = 4;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   logic [BW*NS-1:0] recv_msg = '0;
   logic             recv_val = 1'b0;
   logic             recv_rdy;
   logic [BW-1:0]    send_msg;
   logic             send_val;
   logic             send_rdy = 1'b1;
   logic             dbg_state;

   serializer_vrtl #(.BIT_WIDTH(BW), .N_SAMPLES(NS)) u_dut (
      .clk(clk), .reset(reset), .recv_msg(recv_msg), .recv_val(recv_val), .recv_rdy(recv_rdy),
      .send_msg(send_msg), .send_val(send_val), .send_rdy(send_rdy), .dbg_state(dbg_state)
   );

   logic [255:0] lb_recv_msg = '0;
   logic         lb_recv_val = 1'b0;
   logic         lb_recv_rdy;
   logic [31:0]  lb_send_msg;
   logic         lb_send_val;
   logic         lb_send_rdy = 1'b1;
   logic         lb_dbg_state;

   serializer_vrtl #(.BIT_WIDTH(32), .N_SAMPLES(8)) u_lb (
      .clk(clk), .reset(reset), .recv_msg(lb_recv_msg), .recv_val(lb_recv_val), .recv_rdy(lb_recv_rdy),
      .send_msg(lb_send_msg), .send_val(lb_send_val), .send_rdy(lb_send_rdy), .dbg_state(lb_dbg_state)
   );

   logic [7:0] o_recv_msg = '0;
   logic       o_recv_val = 1'b0;
   logic       o_recv_rdy;
   logic [7:0] o_send_msg;
   logic       o_send_val;
   logic       o_send_rdy = 1'b1;
   logic       o_dbg_state;

   serializer_vrtl #(.BIT_WIDTH(8), .N_SAMPLES(1)) u_one (
      .clk(clk), .reset(reset), .recv_msg(o_recv_msg), .recv_val(o_recv_val), .recv_rdy(o_recv_rdy),
      .send_msg(o_send_msg), .send_val(o_send_val), .send_rdy(o_send_rdy), .dbg_state(o_dbg_state)
   );

   int n_vec = 0;
   int n_mis = 0;
   int cyc = 0;

   logic [BW-1:0] exp_q[$];
   logic [BW-1:0] sent_q[$];
   int            fire_cyc[$];
   logic [31:0]   lb_q[$];
   logic [7:0]    o_q[$];

   logic          s_fire = 1'b0;
   logic          r_fire = 1'b0;
   logic [BW*NS-1:0] r_msg = '0;
   logic          busy;
   logic          rdy_exp;
   logic          prev_stall = 1'b0;
   logic [BW-1:0] prev_msg = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: a frame is a queue of pending words; ready when nothing pending, or only
   // the last word is pending and it leaves this cycle.
   always @(negedge clk) begin
      if (!reset) begin
         check("rst_send_val", {31'b0, send_val}, 32'd0);
         check("rst_send_msg", {28'b0, send_msg}, 32'd0);
         s_fire = 1'b0;
         r_fire = 1'b0;
         prev_stall = 1'b0;
      end else begin
         busy    = (exp_q.size() > 0);
         rdy_exp = (exp_q.size() == 0) || (exp_q.size() == 1 && send_rdy);
         check("send_val", {31'b0, send_val}, {31'b0, busy});
         check("send_msg", {28'b0, send_msg}, busy ? {28'b0, exp_q[0]} : 32'd0);
         check("recv_rdy", {31'b0, recv_rdy}, {31'b0, rdy_exp});
         if (prev_stall) check("hold_msg", {28'b0, send_msg}, {28'b0, prev_msg});
         s_fire     = busy & send_rdy;
         r_fire     = recv_val & rdy_exp;
         r_msg      = recv_msg;
         prev_stall = busy & !send_rdy;
         prev_msg   = send_msg;
      end
      if (reset && lb_send_val && lb_send_rdy) lb_q.push_back(lb_send_msg);
      if (reset && o_send_val && o_send_rdy) o_q.push_back(o_send_msg);
   end

   always @(posedge clk) begin
      cyc++;
      if (reset) begin
         if (s_fire) begin
            sent_q.push_back(exp_q.pop_front());
            fire_cyc.push_back(cyc);
         end
         if (r_fire) begin
            for (int i = 0; i < NS; i++) begin
`ifdef SERIALIZER_MSB_FIRST_EN
               exp_q.push_back(r_msg[BW*(NS-1-i) +: BW]);
`else
               exp_q.push_back(r_msg[BW*i +: BW]);
`endif
            end
         end
      end
      s_fire = 1'b0;
      r_fire = 1'b0;
   end

   always @(negedge reset) exp_q.delete();

   task automatic capture(input logic [BW*NS-1:0] msg, input bit keep_val);
      bit ok;
      ok = 1'b0;
      recv_msg = msg;
      recv_val = 1'b1;
      for (int k = 0; k < 50 && !ok; k++) begin
         @(negedge clk);
         ok = recv_rdy;
         @(posedge clk);
         #1;
      end
      if (!ok) check("capture_timeout", 32'd0, 32'd1);
      if (!keep_val) recv_val = 1'b0;
   endtask

   task automatic wait_idle();
      bit done;
      done = 1'b0;
      for (int k = 0; k < 60 && !done; k++) begin
         @(negedge clk);
         done = (exp_q.size() == 0);
      end
      if (!done) check("idle_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
   endtask

   // Literal emission check for one 4-word frame given in packing order w0..w3.
   task automatic check_frame(input string name, input int base,
                              input logic [3:0] w0, input logic [3:0] w1,
                              input logic [3:0] w2, input logic [3:0] w3);
      logic [3:0] w[4];
`ifdef SERIALIZER_MSB_FIRST_EN
      w = '{w3, w2, w1, w0};
`else
      w = '{w0, w1, w2, w3};
`endif
      for (int k = 0; k < 4; k++) begin
         check(name, (base + k < sent_q.size()) ? {28'b0, sent_q[base+k]} : 32'hdead, {28'b0, w[k]});
      end
   endtask

   initial begin
      logic [255:0] frame;
      bit ok;

      // Reset held with recv_val high: nothing may be captured.
      recv_msg = 16'hDCBA;
      recv_val = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      recv_val = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      check("post_rst_rdy", {31'b0, recv_rdy}, 32'd1);
      @(negedge clk);
      check("post_rst_idle", {31'b0, send_val}, 32'd0);
      @(posedge clk);
      #1;

      // Single frame.
      sent_q.delete();
      capture(16'hDCBA, 1'b0);
      wait_idle();
      check("single_len", sent_q.size(), 32'd4);
      check_frame("single_word", 0, 4'hA, 4'hB, 4'hC, 4'hD);

      // Backpressure pattern.
      sent_q.delete();
      capture(16'hDCBA, 1'b0);
      foreach (u_pat[i]) begin
         send_rdy = u_pat[i];
         @(posedge clk);
         #1;
      end
      send_rdy = 1'b1;
      wait_idle();
      check("bp_len", sent_q.size(), 32'd4);
      check_frame("bp_word", 0, 4'hA, 4'hB, 4'hC, 4'hD);

      // Back-to-back frames with recv_val held.
      sent_q.delete();
      fire_cyc.delete();
      capture(16'h4321, 1'b1);
      capture(16'h8765, 1'b0);
      wait_idle();
      check("b2b_len", sent_q.size(), 32'd8);
      check_frame("b2b_f1", 0, 4'h1, 4'h2, 4'h3, 4'h4);
      check_frame("b2b_f2", 4, 4'h5, 4'h6, 4'h7, 4'h8);
      check("b2b_span", (fire_cyc.size() == 8) ? fire_cyc[7] - fire_cyc[0] : -1, 32'd7);

      // Asynchronous reset after two words.
      sent_q.delete();
      capture(16'hDCBA, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #3;
      reset = 1'b0;
      #1;
      check("async_val", {31'b0, send_val}, 32'd0);
      check("async_msg", {28'b0, send_msg}, 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      check("abort_len", sent_q.size(), 32'd2);
      sent_q.delete();
      capture(16'h1111, 1'b0);
      repeat (3) @(posedge clk);
      wait_idle();
      check("after_rst_len", sent_q.size(), 32'd4);
      check_frame("after_rst", 0, 4'h1, 4'h1, 4'h1, 4'h1);

      // Loopback 32x8 into a packing model of the deserializer.
      for (int f = 0; f < 2; f++) begin
         lb_q.delete();
         for (int i = 0; i < 8; i++) frame[32*i +: 32] = $urandom();
         lb_recv_msg = frame;
         lb_recv_val = 1'b1;
         lb_send_rdy = (f == 0);
         ok = 1'b0;
         for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk);
            ok = lb_recv_rdy;
            @(posedge clk);
            #1;
         end
         lb_recv_val = 1'b0;
         for (int k = 0; k < 40 && lb_q.size() < 8; k++) begin
            lb_send_rdy = (f == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
         end
         lb_send_rdy = 1'b1;
         repeat (2) @(posedge clk);
         #1;
         check("lb_len", lb_q.size(), 32'd8);
         for (int i = 0; i < 8; i++) begin
`ifdef SERIALIZER_MSB_FIRST_EN
            check("lb_word", (i < lb_q.size()) ? lb_q[i] : 32'hdeadbeef, frame[32*(7-i) +: 32]);
`else
            check("lb_word", (i < lb_q.size()) ? lb_q[i] : 32'hdeadbeef, frame[32*i +: 32]);
`endif
         end
      end

      // N_SAMPLES==1: pass-through ready, one word per cycle.
      o_q.delete();
      o_recv_val = 1'b1;
      foreach (o_vals[i]) begin
         o_recv_msg = o_vals[i];
         @(negedge clk);
         if (i > 0) check("one_rdy", {31'b0, o_recv_rdy}, 32'd1);
         @(posedge clk);
         #1;
      end
      o_recv_val = 1'b0;
      o_send_rdy = 1'b0;
      @(negedge clk);
      check("one_stall_rdy", {31'b0, o_recv_rdy}, 32'd0);
      check("one_stall_msg", {24'b0, o_send_msg}, 32'h33);
      @(posedge clk);
      #1;
      o_send_rdy = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("one_len", o_q.size(), 32'd3);
      foreach (o_vals[i]) check("one_word", (i < o_q.size()) ? {24'b0, o_q[i]} : 32'hdead, {24'b0, o_vals[i]});

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

   logic       u_pat[7]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
   logic [7:0] o_vals[3] = '{8'h11, 8'h22, 8'h33};

   initial begin
      #200000;
      $display("FAIL global_timeout: got running, expected finished");
      $fatal(1);
   end

endmodule
